gcm_ctr_scheduler: RTL and testbench

Sequencer that feeds the fixed-latency AES-CTR datapath of the GCM core. Per message it:
- issues the pre-counter block J0;
- issues one counter block per plaintext block, with the plaintext driven into the 128-bit plaintext bypass delay line in the same cycle;
- generates a valid/last token stream aligned with the datapath output;
- throttles issue with a credit count so the downstream GHASH/output FIFO never overflows.

It sits between the host-side plaintext stream and the AES pipeline plus its plaintext bypass chain.

---
 rtl/gcm_ctr_scheduler_if.sv | 40 ++++
 rtl/gcm_ctr_scheduler.sv | 132 +++++++++++++
 tb/tb_gcm_ctr_scheduler.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gcm_ctr_scheduler_if.sv
// gcm_ctr_scheduler_if
//   Bundles every non-clock/reset signal of the GCM counter scheduler.
//   master : host/test side (drives i_*, observes o_*)
//   slave  : scheduler side (observes i_*, drives o_*)
//   Message control : i_start, i_iv[95:0], i_len_blocks[15:0], o_busy, o_done
//   Plaintext in    : i_pt_valid, i_pt[127:0], o_pt_ready
//   Pipeline issue  : o_issue_valid, o_ctr_block[127:0], o_text[127:0], o_issue_j0
//   Output tokens   : o_valid_out, o_j0_out, o_last_out
//   Credit return   : i_out_pop, o_credit_err
interface gcm_ctr_scheduler_if;
  logic         i_start;
  logic [95:0]  i_iv;
  logic [15:0]  i_len_blocks;
  logic         i_pt_valid;
  logic [127:0] i_pt;
  logic         o_pt_ready;
  logic         o_issue_valid;
  logic [127:0] o_ctr_block;
  logic [127:0] o_text;
  logic         o_issue_j0;
  logic         o_valid_out;
  logic         o_j0_out;
  logic         o_last_out;
  logic         i_out_pop;
  logic         o_busy;
  logic         o_done;
  logic         o_credit_err;

  modport master (
    output i_start, i_iv, i_len_blocks, i_pt_valid, i_pt, i_out_pop,
    input  o_pt_ready, o_issue_valid, o_ctr_block, o_text, o_issue_j0,
           o_valid_out, o_j0_out, o_last_out, o_busy, o_done, o_credit_err
  );

  modport slave (
    input  i_start, i_iv, i_len_blocks, i_pt_valid, i_pt, i_out_pop,
    output o_pt_ready, o_issue_valid, o_ctr_block, o_text, o_issue_j0,
           o_valid_out, o_j0_out, o_last_out, o_busy, o_done, o_credit_err
  );
endinterface

// File: rtl/gcm_ctr_scheduler.sv
// gcm_ctr_scheduler
//   Sequences one GCM message into a fixed-latency AES-CTR datapath:
//   issues J0 = {IV, 1}, then one counter block {IV, ctr} per plaintext
//   block (plaintext forwarded to the bypass line in the same cycle), and
//   tracks a {valid, j0, last} token alongside the datapath so the result
//   flags line up with the AES output. Issue is throttled by a credit count
//   mirroring free space in the downstream result FIFO.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : gcm_ctr_scheduler_if.slave (see interface file)
// Parameters:
//   LATENCY  : cycles from o_issue_valid to the matching o_valid_out
//   CREDITS  : downstream FIFO depth
//   CTR_INIT : first data counter value (2 for GCM; other values only
//              for exercising the 32-bit counter wrap)
module gcm_ctr_scheduler #(
  parameter int          LATENCY  = 14,
  parameter int          CREDITS  = 16,
  parameter logic [31:0] CTR_INIT = 32'd2
) (
  input logic                clk,
  input logic                rst_n,
  gcm_ctr_scheduler_if.slave bus
);
  localparam int CW = $clog2(CREDITS + 1);
  localparam int FW = $clog2(LATENCY + 2);
  localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);

  typedef enum logic [1:0] {S_IDLE, S_J0, S_RUN, S_DRAIN} state_e;

  state_e        state_q, state_d;
  logic [95:0]   iv_q;
  logic [31:0]   ctr_q;
  logic [15:0]   rem_q;
  logic [CW-1:0] cred_q;
  logic [FW-1:0] inflight_q;
  logic          err_q;
  logic [127:0]  ctr_block_q, text_q;

  // Stage 0 is the issue register seen at the pipeline input; stage
  // LATENCY lines up with the datapath result.
  logic [LATENCY:0] vld_pipe_q, j0_pipe_q, last_pipe_q;

  logic pt_ready, issue, issue_j0, issue_dat, pop_ok, tok_exit, done;

  assign pt_ready  = (state_q == S_RUN) & (rem_q != '0) & (cred_q != '0);
  assign issue     = issue_j0 | issue_dat;
  // A pop with every credit already home has nothing to return.
  assign pop_ok    = bus.i_out_pop & (cred_q != CRED_MAX);
  assign tok_exit  = vld_pipe_q[LATENCY];

  always_comb begin
    state_d   = state_q;
    issue_j0  = 1'b0;
    issue_dat = 1'b0;
    done      = 1'b0;
    case (state_q)
      S_IDLE:  if (bus.i_start) state_d = S_J0;
      S_J0: begin
        if (cred_q != '0) begin
          issue_j0 = 1'b1;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        issue_dat = bus.i_pt_valid & pt_ready;
        if ((rem_q == '0) || (issue_dat && rem_q == 16'd1)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (inflight_q == '0) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iv_q        <= '0;
      ctr_q       <= '0;
      rem_q       <= '0;
      cred_q      <= CRED_MAX;
      inflight_q  <= '0;
      err_q       <= 1'b0;
      ctr_block_q <= '0;
      text_q      <= '0;
      vld_pipe_q  <= '0;
      j0_pipe_q   <= '0;
      last_pipe_q <= '0;
    end else begin
      if (state_q == S_IDLE && bus.i_start) begin
        iv_q  <= bus.i_iv;
        ctr_q <= CTR_INIT;
        rem_q <= bus.i_len_blocks;
      end
      if (issue_dat) begin
        ctr_q <= ctr_q + 32'd1;   // wraps mod 2^32, IV untouched
        rem_q <= rem_q - 16'd1;
      end
      if (issue) begin
        ctr_block_q <= issue_j0 ? {iv_q, 32'd1} : {iv_q, ctr_q};
        text_q      <= issue_j0 ? '0 : bus.i_pt;
      end
      vld_pipe_q  <= {vld_pipe_q[LATENCY-1:0], issue};
      j0_pipe_q   <= {j0_pipe_q[LATENCY-1:0], issue_j0};
      last_pipe_q <= {last_pipe_q[LATENCY-1:0], issue_dat & (rem_q == 16'd1)};
      cred_q      <= cred_q - CW'(issue) + CW'(pop_ok);
      inflight_q  <= inflight_q + FW'(issue) - FW'(tok_exit);
      if (bus.i_out_pop && cred_q == CRED_MAX) err_q <= 1'b1;
    end
  end

  assign bus.o_pt_ready    = pt_ready;
  assign bus.o_issue_valid = vld_pipe_q[0];
  assign bus.o_issue_j0    = j0_pipe_q[0];
  assign bus.o_ctr_block   = ctr_block_q;
  assign bus.o_text        = text_q;
  assign bus.o_valid_out   = vld_pipe_q[LATENCY];
  assign bus.o_j0_out      = j0_pipe_q[LATENCY];
  assign bus.o_last_out    = last_pipe_q[LATENCY];
  assign bus.o_busy        = (state_q != S_IDLE);
  assign bus.o_done        = done;
  assign bus.o_credit_err  = err_q;
endmodule

// File: tb/tb_gcm_ctr_scheduler.sv
// Bench for gcm_ctr_scheduler: a message-level reference model (credits,
// remaining count, expected results keyed by absolute cycle) is checked
// against the DUT on every negedge, plus literal expectations per scenario.
// A second instance starts its data counter at 32'hFFFFFFFF for the wrap case.
module tb_gcm_ctr_scheduler;
  localparam int LAT  = 14;
  localparam int CRED = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  gcm_ctr_scheduler_if b();
  gcm_ctr_scheduler_if b2();

  gcm_ctr_scheduler #(.LATENCY(LAT), .CREDITS(CRED)) dut (
    .clk(clk), .rst_n(rst_n), .bus(b.slave));
  gcm_ctr_scheduler #(.LATENCY(LAT), .CREDITS(CRED), .CTR_INIT(32'hFFFF_FFFF)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(b2.slave));

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // m_phase: 0 no message, 1 waiting to issue J0, 2 issuing/draining data
  int          m_phase, m_cred, m_rem, m_done_cyc;
  logic [95:0] m_iv;
  logic [31:0] m_ctr;
  logic        m_err;
  logic [1:0]  m_out [int];     // cycle -> {j0,last} of the result due then
  logic        e_iv, e_j0;
  logic [127:0] e_blk, e_txt;

  // logs for scenario-level literal checks
  logic [127:0] iss_q[$];
  int           iss_cyc_q[$];
  int           out_q[$];
  logic [1:0]   oflag_q[$];
  int           done_n, ready_n, last_n;
  logic [127:0] q2[$];

  task automatic model_reset();
    m_phase = 0; m_cred = CRED; m_rem = 0; m_done_cyc = -1;
    m_iv = '0; m_ctr = '0; m_err = 1'b0; m_out.delete();
    e_iv = 1'b0; e_j0 = 1'b0; e_blk = '0; e_txt = '0;
  endtask

  task automatic clear_logs();
    iss_q.delete(); iss_cyc_q.delete(); out_q.delete(); oflag_q.delete();
    done_n = 0; ready_n = 0; last_n = 0;
  endtask

  initial begin
    model_reset();
    clear_logs();
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("reset_outputs_zero", |{b.o_pt_ready, b.o_issue_valid, b.o_ctr_block, b.o_text,
            b.o_issue_j0, b.o_valid_out, b.o_j0_out, b.o_last_out, b.o_busy, b.o_done,
            b.o_credit_err}, 1'b0);
        model_reset();
      end else begin
        logic iss, j0, last;
        logic [1:0] ef;
        if (b.o_issue_valid) begin iss_q.push_back(b.o_ctr_block); iss_cyc_q.push_back(cyc); end
        if (b.o_valid_out) begin out_q.push_back(cyc); oflag_q.push_back({b.o_j0_out, b.o_last_out}); end
        if (b.o_done) done_n++;
        if (b.o_pt_ready) ready_n++;
        if (b.o_last_out) last_n++;

        chk("busy", b.o_busy, m_phase != 0);
        chk("pt_ready", b.o_pt_ready, (m_phase == 2) && (m_rem > 0) && (m_cred > 0));
        chk("issue_valid", b.o_issue_valid, e_iv);
        if (e_iv) begin
          chk("ctr_block", b.o_ctr_block, e_blk);
          chk("text", b.o_text, e_txt);
          chk("issue_j0", b.o_issue_j0, e_j0);
        end
        ef = m_out.exists(cyc) ? m_out[cyc] : 2'b00;
        chk("result_flags", {b.o_valid_out, b.o_j0_out, b.o_last_out},
            {m_out.exists(cyc), ef});
        m_out.delete(cyc);
        chk("done", b.o_done, cyc == m_done_cyc);
        chk("credit_err", b.o_credit_err, m_err);

        // advance the model across the coming edge
        iss = 1'b0; j0 = 1'b0; last = 1'b0;
        if (m_phase == 1 && m_cred > 0) begin
          iss = 1'b1; j0 = 1'b1;
          e_blk = {m_iv, 32'd1}; e_txt = '0;
          m_phase = 2;
          if (m_rem == 0) m_done_cyc = cyc + LAT + 2;
        end else if (m_phase == 2 && m_rem > 0 && m_cred > 0 && b.i_pt_valid) begin
          iss = 1'b1;
          e_blk = {m_iv, m_ctr}; e_txt = b.i_pt;
          m_ctr = m_ctr + 32'd1;
          m_rem--;
          if (m_rem == 0) begin last = 1'b1; m_done_cyc = cyc + LAT + 2; end
        end
        e_iv = iss;
        if (iss) begin e_j0 = j0; m_out[cyc + 1 + LAT] = {j0, last}; end
        if (cyc == m_done_cyc) begin
          m_phase = 0; m_done_cyc = -1;
        end else if (m_phase == 0 && b.i_start) begin
          m_phase = 1; m_iv = b.i_iv; m_rem = int'(b.i_len_blocks); m_ctr = 32'd2;
        end
        if (b.i_out_pop) begin
          if (m_cred == CRED) m_err = 1'b1;
          else m_cred++;
        end
        if (iss) m_cred--;
      end
      cyc++;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && b2.o_issue_valid) q2.push_back(b2.o_ctr_block);
    end
  end

  // ---------------- stimulus ----------------
  int pop_mode = 0;   // 0 none, 1 pop on every result, 2 random pops
  bit pv_rand  = 1'b0;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic step();
    b.i_pt_valid = pv_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    b.i_pt       = {$urandom, $urandom, $urandom, $urandom};
    case (pop_mode)
      1:       b.i_out_pop = b.o_valid_out;
      2:       b.i_out_pop = (m_cred < CRED) && ($urandom_range(0, 1) == 1);
      default: b.i_out_pop = 1'b0;
    endcase
    tick();
  endtask

  task automatic start_msg(input logic [95:0] iv, input logic [15:0] len);
    b.i_start = 1'b1; b.i_iv = iv; b.i_len_blocks = len;
    step();
    b.i_start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int n = 0;
    while (m_phase != 0 && n < budget) begin step(); n++; end
    chk({nm, "_finished_in_budget"}, m_phase == 0, 1'b1);
  endtask

  task automatic restore_credits();
    int n = 0;
    b.i_start = 1'b0;
    while (m_cred < CRED && n < 40) begin b.i_out_pop = 1'b1; tick(); n++; end
    b.i_out_pop = 1'b0;
    chk("credits_restored", m_cred, CRED);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    b.i_start = 0; b.i_iv = '0; b.i_len_blocks = '0; b.i_pt_valid = 0; b.i_pt = '0; b.i_out_pop = 0;
    b2.i_start = 0; b2.i_iv = '0; b2.i_len_blocks = '0; b2.i_pt_valid = 0; b2.i_pt = '0; b2.i_out_pop = 0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", b.o_busy, 1'b0);
    chk("rst_issue_valid", b.o_issue_valid, 1'b0);
    chk("rst_pt_ready", b.o_pt_ready, 1'b0);
    rst_n = 1'b1;
    tick();

    // Basic: J0 + 3 data blocks, pop each result as it appears.
    clear_logs(); pop_mode = 1; pv_rand = 1'b0;
    start_msg(96'hCAFE_0000_0000_0000_0000_0001, 16'd3);
    wait_idle(80, "basic");
    chk("basic_issue_count", iss_q.size(), 4);
    if (iss_q.size() == 4)
      chk("basic_ctrs", {iss_q[0][31:0], iss_q[1][31:0], iss_q[2][31:0], iss_q[3][31:0]},
          {32'd1, 32'd2, 32'd3, 32'd4});
    chk("basic_result_count", out_q.size(), 4);
    if (out_q.size() == 4 && iss_cyc_q.size() > 0) begin
      // result appears LATENCY cycles after its o_issue_valid cycle
      chk("basic_first_latency", out_q[0] - iss_cyc_q[0], LAT);
      chk("basic_consecutive", out_q[3] - out_q[0], 3);
      chk("basic_flags", {oflag_q[0], oflag_q[1], oflag_q[2], oflag_q[3]}, 8'b10_00_00_01);
    end
    chk("basic_done_once", done_n, 1);

    // Zero-length message: J0 only.
    clear_logs();
    start_msg(96'h1234_5678_9ABC_DEF0_1111_2222, 16'd0);
    wait_idle(60, "zero");
    chk("zero_issue_count", iss_q.size(), 1);
    chk("zero_no_last", last_n, 0);
    chk("zero_done_once", done_n, 1);
    chk("zero_never_ready", ready_n, 0);

    // Credit stall: L=20, no pops.
    clear_logs(); pop_mode = 0;
    start_msg({$urandom, $urandom, $urandom}, 16'd20);
    repeat (40) step();
    chk("stall_issue_count", iss_q.size(), 16);
    chk("stall_ready_low", b.o_pt_ready, 1'b0);
    b.i_out_pop = 1'b1; tick(); b.i_out_pop = 1'b0;
    repeat (10) step();
    chk("stall_one_pop_one_issue", iss_q.size(), 17);
    repeat (15) begin b.i_out_pop = 1'b1; tick(); end
    b.i_out_pop = 1'b0;
    wait_idle(100, "stall");
    chk("stall_total_issues", iss_q.size(), 21);
    chk("stall_done_once", done_n, 1);
    restore_credits();

    // Counter wrap on the second instance.
    b2.i_start = 1'b1; b2.i_iv = 96'hA5A5_0000_FFFF_1234_5678_9ABC; b2.i_len_blocks = 16'd2;
    b2.i_pt_valid = 1'b1;
    tick();
    b2.i_start = 1'b0;
    repeat (8) tick();
    chk("wrap_issue_count", q2.size(), 3);
    if (q2.size() == 3) begin
      chk("wrap_j0", q2[0], {96'hA5A5_0000_FFFF_1234_5678_9ABC, 32'd1});
      chk("wrap_first", q2[1], {96'hA5A5_0000_FFFF_1234_5678_9ABC, 32'hFFFF_FFFF});
      chk("wrap_second", q2[2], {96'hA5A5_0000_FFFF_1234_5678_9ABC, 32'h0000_0000});
    end

    // Overlap: stray i_start mid-RUN is ignored; pop with credits full.
    clear_logs(); pop_mode = 1; pv_rand = 1'b1;
    start_msg(96'h0BAD_F00D_0000_1111_2222_3333, 16'd10);
    repeat (6) step();
    b.i_start = 1'b1; b.i_iv = 96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF; b.i_len_blocks = 16'd5;
    step();
    b.i_start = 1'b0;
    wait_idle(200, "overlap");
    chk("overlap_issue_count", iss_q.size(), 11);
    chk("overlap_last_once", last_n, 1);
    pop_mode = 0;
    b.i_out_pop = 1'b1; tick(); b.i_out_pop = 1'b0; tick();
    chk("credit_err_set", b.o_credit_err, 1'b1);
    repeat (5) step();
    chk("credit_err_sticky", b.o_credit_err, 1'b1);

    // Mid-operation reset with tokens in flight.
    clear_logs(); pv_rand = 1'b0; pop_mode = 0;
    start_msg({$urandom, $urandom, $urandom}, 16'd30);
    begin
      int n = 0;
      while (iss_q.size() < 5 && n < 60) begin step(); n++; end
    end
    chk("midrst_reached_5", iss_q.size() >= 5, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midrst_async_zero", |{b.o_pt_ready, b.o_issue_valid, b.o_ctr_block, b.o_text,
        b.o_issue_j0, b.o_valid_out, b.o_j0_out, b.o_last_out, b.o_busy, b.o_done,
        b.o_credit_err}, 1'b0);
    b.i_pt_valid = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    clear_logs();
    repeat (20) step();
    chk("midrst_no_results", out_q.size(), 0);
    chk("midrst_no_done", done_n, 0);
    clear_logs();
    start_msg({$urandom, $urandom, $urandom}, 16'd15);
    wait_idle(120, "post_reset");
    chk("post_reset_16_issues", iss_q.size(), 16);
    chk("post_reset_done", done_n, 1);
    restore_credits();

    // Randomized messages with random valid gaps, random pops, stray starts.
    pv_rand = 1'b1; pop_mode = 2;
    for (int m = 0; m < 12; m++) begin
      start_msg({$urandom, $urandom, $urandom}, 16'($urandom_range(0, 24)));
      repeat ($urandom_range(0, 5)) step();
      b.i_start = 1'b1; b.i_iv = {$urandom, $urandom, $urandom};
      b.i_len_blocks = 16'($urandom_range(0, 24));
      step();
      b.i_start = 1'b0;
      wait_idle(600, "random");
      repeat ($urandom_range(0, 3)) step();
    end
    restore_credits();
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
